// File: rtl/control_filtro_pkg.sv
// Shared definitions for the biquad sequencer: state encoding, operand selectors
// and the fixed timing constants of one sample.
package control_filtro_pkg;

  typedef enum logic [3:0] {
    IDLE, CLR_A, MAC_A, WR_F, CLR_B, MAC_B, WR_Y, SHIFT, FIN
  } state_t;

  localparam logic [3:0] SEL_B0 = 4'd0;
  localparam logic [3:0] SEL_B1 = 4'd1;
  localparam logic [3:0] SEL_B2 = 4'd2;
  localparam logic [3:0] SEL_A0 = 4'd3;
  localparam logic [3:0] SEL_A1 = 4'd4;
  localparam logic [3:0] SEL_A2 = 4'd5;

  localparam int MAC_PASOS = 3;
  localparam int LATENCIA  = 12;

endpackage

// File: rtl/control_filtro_if.sv
// Control bundle between the sequencer (slave side) and whoever requests samples.
interface control_filtro_if #(
  parameter int SEL_W = 4
);
  logic             inicio;
  logic [SEL_W-1:0] sel;
  logic             rst_acum;
  logic             leer;
  logic             leer_y;
  logic             desp;
  logic             ocupado;
  logic             listo;
  logic             sobrecarga;

  modport master (
    output inicio,
    input  sel, rst_acum, leer, leer_y, desp, ocupado, listo, sobrecarga
  );

  modport slave (
    input  inicio,
    output sel, rst_acum, leer, leer_y, desp, ocupado, listo, sobrecarga
  );
endinterface

// File: rtl/control_filtro.sv
// Fixed-latency sequencer for a two-stage MAC filter datapath (12 cycles per sample).
// Define CONTROL_FILTRO_SOBRECARGA_EN to build the sticky overrun flag.
module control_filtro
  import control_filtro_pkg::*;
#(
  parameter int               SEL_W    = 4,
  parameter logic [SEL_W-1:0] SEL_IDLE = 4'd0
) (
  input  logic                clk,
  input  logic                rst,
  control_filtro_if.slave     bus
);

  state_t           state;
  logic [1:0]       paso;
  logic [SEL_W-1:0] sel;
  logic             rst_acum, leer, leer_y, desp, ocupado, listo;

  localparam logic [1:0] ULTIMO = 2'(MAC_PASOS - 1);

  // Every output is set on the transition into the state it belongs to,
  // so all of them come straight from flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      paso     <= '0;
      sel      <= SEL_IDLE;
      rst_acum <= 1'b0;
      leer     <= 1'b0;
      leer_y   <= 1'b0;
      desp     <= 1'b0;
      ocupado  <= 1'b0;
      listo    <= 1'b0;
    end else begin
      rst_acum <= 1'b0;
      leer     <= 1'b0;
      leer_y   <= 1'b0;
      desp     <= 1'b0;
      listo    <= 1'b0;
      case (state)
        IDLE: if (bus.inicio) begin
          state    <= CLR_A;
          rst_acum <= 1'b1;
          ocupado  <= 1'b1;
          paso     <= '0;
          sel      <= SEL_W'(SEL_B0);
        end
        CLR_A: begin
          state <= MAC_A;
          paso  <= '0;
          sel   <= SEL_W'(SEL_B0);
        end
        MAC_A: if (paso == ULTIMO) begin
          state <= WR_F;
          leer  <= 1'b1;
        end else begin
          paso <= paso + 2'd1;
          sel  <= sel + SEL_W'(1);
        end
        WR_F: begin
          state    <= CLR_B;
          rst_acum <= 1'b1;
          sel      <= SEL_W'(SEL_A0);
        end
        CLR_B: begin
          state <= MAC_B;
          paso  <= '0;
          sel   <= SEL_W'(SEL_A0);
        end
        MAC_B: if (paso == ULTIMO) begin
          state  <= WR_Y;
          leer_y <= 1'b1;
        end else begin
          paso <= paso + 2'd1;
          sel  <= sel + SEL_W'(1);
        end
        WR_Y: begin
          state <= SHIFT;
          desp  <= 1'b1;
        end
        SHIFT: begin
          state <= FIN;
          listo <= 1'b1;
        end
        FIN: begin
          state   <= IDLE;
          ocupado <= 1'b0;
          sel     <= SEL_IDLE;
        end
        default: begin
          state   <= IDLE;
          ocupado <= 1'b0;
          sel     <= SEL_IDLE;
        end
      endcase
    end
  end

  assign bus.sel      = sel;
  assign bus.rst_acum = rst_acum;
  assign bus.leer     = leer;
  assign bus.leer_y   = leer_y;
  assign bus.desp     = desp;
  assign bus.ocupado  = ocupado;
  assign bus.listo    = listo;

`ifdef CONTROL_FILTRO_SOBRECARGA_EN
  logic sobrecarga;

  // Requests are only taken in IDLE; anything else (FIN included) is an overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             sobrecarga <= 1'b0;
    else if (bus.inicio && state != IDLE) sobrecarga <= 1'b1;
  end

  assign bus.sobrecarga = sobrecarga;
`else
  assign bus.sobrecarga = 1'b0;
`endif

endmodule

// File: tb/tb_control_filtro.sv
// Scoreboard bench for control_filtro: timeline model of accepted requests plus a
// behavioural filter datapath driven by the strobes.
module tb_control_filtro;
  import control_filtro_pkg::*;

  localparam int               SEL_W    = 4;
  localparam logic [SEL_W-1:0] SEL_IDLE = 4'd0;
  localparam int               SPACING  = LATENCIA + 1;
`ifdef CONTROL_FILTRO_SOBRECARGA_EN
  localparam bit SOB_EN = 1'b1;
`else
  localparam bit SOB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  control_filtro_if #(.SEL_W(SEL_W)) bus();

  control_filtro #(.SEL_W(SEL_W), .SEL_IDLE(SEL_IDLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int exp_q[$];            // cycle in which each accepted inicio was sampled
  int last_acc = -1000;
  int sob_from = -1;       // first cycle sobrecarga must read 1, -1 = never
  int n_acc = 0;
  int n_listo = 0;

  // Expected {rst_acum,leer,leer_y,desp,ocupado,listo} and sel (-1 = free) at a
  // given cycle offset from the sampled inicio.
  function automatic void ref_cycle(input int off, output logic [5:0] v, output int s);
    v = 6'b000010;
    s = -1;
    case (off)
      1, 6:    v[5] = 1'b1;
      2, 3, 4: s = int'(SEL_B0) + off - 2;
      5:       begin v[4] = 1'b1; s = int'(SEL_B2); end
      7, 8, 9: s = int'(SEL_A0) + off - 7;
      10:      v[3] = 1'b1;
      11:      v[2] = 1'b1;
      12:      v[0] = 1'b1;
      default: ;
    endcase
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    last_acc = -1000;
    sob_from = -1;
  endfunction

  // One stimulus cycle: drive inicio and let the model decide whether it is taken.
  task automatic step(input bit v);
    @(posedge clk);
    #1;
    bus.inicio = v;
    if (v) begin
      if (cyc >= last_acc + SPACING) begin
        exp_q.push_back(cyc);
        last_acc = cyc;
        n_acc++;
      end else if (SOB_EN && sob_from < 0) begin
        sob_from = cyc + 1;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sel"}, bus.sel == SEL_IDLE, bus.sel, SEL_IDLE);
    chk({tag, "_outs"},
        {bus.rst_acum, bus.leer, bus.leer_y, bus.desp, bus.ocupado, bus.listo, bus.sobrecarga} == 7'd0,
        {bus.rst_acum, bus.leer, bus.leer_y, bus.desp, bus.ocupado, bus.listo, bus.sobrecarga}, 0);
  endtask

  task automatic assert_rst(input string tag);
    bus.inicio = 1'b0;
    rst = 1'b0;
    model_clear();
    #1 check_reset_outputs(tag);
  endtask

  task automatic release_rst();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1 assert_rst(tag);
    release_rst();
  endtask

  // ---------------- monitor ----------------
  logic [5:0] m_act, m_exp;
  int         m_sel, m_off;
  bit         m_sob;

  always @(negedge clk) begin
    m_act = {bus.rst_acum, bus.leer, bus.leer_y, bus.desp, bus.ocupado, bus.listo};
    if (bus.listo) n_listo++;
    if (exp_q.size() != 0 && cyc > exp_q[0]) begin
      m_off = cyc - exp_q[0];
      ref_cycle(m_off, m_exp, m_sel);
      chk("seq_outs", m_act == m_exp, m_act, m_exp);
      if (m_sel >= 0) chk("seq_sel", int'(bus.sel) == m_sel, bus.sel, m_sel);
      if (m_off == LATENCIA) void'(exp_q.pop_front());
    end else begin
      chk("idle_outs", m_act == 6'd0, m_act, 0);
      chk("idle_sel", bus.sel == SEL_IDLE, bus.sel, SEL_IDLE);
    end
    chk("one_strobe", $countones(m_act[5:2]) <= 1, m_act[5:2], 0);
    if (bus.ocupado) chk("sel_range", bus.sel <= 5, bus.sel, 5);
    m_sob = (sob_from >= 0) && (cyc >= sob_from);
    chk("sobrecarga", bus.sobrecarga == m_sob, bus.sobrecarga, m_sob);
  end

  // ---------------- behavioural filter datapath ----------------
  // Q8 coefficients: w = u + 0.75*w1 - 0.125*w2 ; y = 0.125*(w + w1 + w2).
  int     coef [6] = '{256, 192, -32, 32, 32, 32};
  longint uu, acc, w0, w1, w2, y_reg, opnd;

  function automatic longint rnd(input longint a);
    return (a + 64'sd128) >>> 8;
  endfunction

  always_comb begin
    opnd = 0;
    case (bus.sel)
      4'd0: opnd = uu;
      4'd1: opnd = w1;
      4'd2: opnd = w2;
      4'd3: opnd = w0;
      4'd4: opnd = w1;
      4'd5: opnd = w2;
      default: opnd = 0;
    endcase
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= 0; w0 <= 0; w1 <= 0; w2 <= 0; y_reg <= 0;
    end else begin
      if (bus.rst_acum) acc <= 0;
      else if (bus.ocupado && !(bus.leer || bus.leer_y || bus.desp || bus.listo) && bus.sel <= 5)
        acc <= acc + longint'(coef[bus.sel]) * opnd;
      if (bus.leer)   w0 <= rnd(acc);
      if (bus.leer_y) y_reg <= rnd(acc);
      if (bus.desp) begin
        w2 <= w1;
        w1 <= w0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int s0, base_l, base_a;
    longint prev_y, y_ss;
    real gain;

    bus.inicio = 1'b0;
    uu = 0;
    #1 assert_rst("por");
    release_rst();

    // single sample, then a second request 5 cycles in (ignored)
    base_l = n_listo;
    step(1);
    repeat (4) step(0);
    step(1);
    repeat (12) step(0);
    chk("one_listo", n_listo - base_l == 1, n_listo - base_l, 1);
    chk("overrun_flag", bus.sobrecarga == SOB_EN, bus.sobrecarga, SOB_EN);

    // back-to-back at the minimum spacing
    do_reset("rst2");
    base_l = n_listo;
    for (int i = 0; i < 20; i++) begin
      step(1);
      repeat (SPACING - 1) step(0);
    end
    repeat (2) step(0);
    chk("listo_20", n_listo - base_l == 20, n_listo - base_l, 20);
    chk("no_overrun", bus.sobrecarga == 1'b0, bus.sobrecarga, 0);

    // abort in MAC_B at sel=4
    do_reset("rst3");
    step(1);
    s0 = last_acc;
    while (cyc < s0 + 8) step(0);
    #1 chk("pre_abort_sel", bus.sel == SEL_W'(SEL_A1), bus.sel, SEL_A1);
    assert_rst("abort");
    base_l = n_listo;
    release_rst();
    repeat (4) step(0);
    chk("abort_no_listo", n_listo == base_l, n_listo - base_l, 0);
    step(1);
    repeat (14) step(0);
    chk("after_abort", n_listo - base_l == 1, n_listo - base_l, 1);

    // random request traffic
    do_reset("rst4");
    base_l = n_listo;
    base_a = n_acc;
    repeat (400) step($urandom_range(0, 3) == 0);
    repeat (SPACING + 2) step(0);
    chk("rand_listo", n_listo - base_l == n_acc - base_a, n_listo - base_l, n_acc - base_a);
    chk("rand_drained", exp_q.size() == 0, exp_q.size(), 0);

    // step response of the filter
    do_reset("rst5");
    uu = 1000;
    prev_y = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      repeat (LATENCIA) step(0);
      chk("y_mono", y_reg >= prev_y - 1, y_reg, prev_y);
      prev_y = y_reg;
    end
    gain = (real'(coef[3] + coef[4] + coef[5]) / 256.0) /
           (1.0 - real'(coef[1] + coef[2]) / 256.0);
    y_ss = longint'($rtoi(gain * 1000.0 + 0.5));
    chk("y_settle", (y_reg - y_ss <= 1) && (y_ss - y_reg <= 1), y_reg, y_ss);

    repeat (2) step(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/control_filtro.md
CONTROL_FILTRO -- requirements
Module: control_filtro

Interface
REQ-001 The block SHALL have parameter SEL_IDLE, default 4'd0, which is the sel value driven while no sample is being processed.
REQ-002 The block SHALL have parameter SEL_W, default 4, which is the width of the sel output.
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock (rising edge).
REQ-004 The block SHALL have port rst, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have port inicio, input, 1 bit, a one-cycle request to process a new sample on uu.
REQ-006 The block SHALL have port sel, output, SEL_W bits, the constant and operand selector for the filter datapath.
REQ-007 The block SHALL have port rst_acum, output, 1 bit, the synchronous clear of the datapath accumulator.
REQ-008 The block SHALL have port leer, output, 1 bit, the write strobe that stores the rounded intermediate into the delay memory.
REQ-009 The block SHALL have port leer_y, output, 1 bit, the load strobe of the output register y.
REQ-010 The block SHALL have port desp, output, 1 bit, the shift strobe of the delay memory.
REQ-011 The block SHALL have port ocupado, output, 1 bit, high while a sample is in progress.
REQ-012 The block SHALL have port listo, output, 1 bit, a one-cycle pulse when a sample completes.
REQ-013 The block SHALL have port sobrecarga, output, 1 bit, a sticky overrun flag.

Function
REQ-014 The FSM states SHALL be IDLE, CLR_A, MAC_A, WR_F, CLR_B, MAC_B, WR_Y, SHIFT and FIN.
REQ-015 IDLE SHALL go to CLR_A when inicio=1; otherwise it stays in IDLE with sel=SEL_IDLE and all strobes at 0.
REQ-016 CLR_A SHALL drive rst_acum=1 for one cycle and then go to MAC_A.
REQ-017 MAC_A SHALL last 3 cycles with sel=0,1,2 in consecutive cycles, using a 2-bit step counter, and then go to WR_F.
REQ-018 WR_F SHALL drive leer=1 for one cycle (sel held at 2), and then go to CLR_B.
REQ-019 CLR_B SHALL drive rst_acum=1 for one cycle and then go to MAC_B.
REQ-020 MAC_B SHALL last 3 cycles with sel=3,4,5, and then go to WR_Y.
REQ-021 WR_Y SHALL drive leer_y=1 for one cycle, and then go to SHIFT.
REQ-022 SHIFT SHALL drive desp=1 for one cycle, and then go to FIN.
REQ-023 FIN SHALL drive listo=1 for one cycle, and then go to IDLE.
REQ-024 Latency SHALL be fixed: listo is high exactly 12 cycles after the cycle in which inicio is sampled.
REQ-025 The minimum sample spacing SHALL be 13 cycles.
REQ-026 ocupado SHALL be 1 in every state except IDLE.
REQ-027 At most one of rst_acum, leer, leer_y and desp SHALL be high in any cycle.
REQ-028 All outputs SHALL be registered, or decoded only from the state and step counter; no input SHALL reach an output combinationally.
REQ-029 An inicio that arrives while ocupado=1 SHALL be ignored, and the current sequence SHALL continue unchanged.
REQ-030 An inicio in the same cycle as FIN SHALL be ignored; a new request is accepted only in IDLE.
REQ-031 sel values 6 to 15 SHALL never be driven except when SEL_IDLE is set to one of them.

Reset
REQ-032 When rst=0, the block SHALL immediately enter IDLE, clear the step counter, drive sel=SEL_IDLE, drive all strobes, ocupado and listo to 0, and clear sobrecarga.
REQ-033 A reset in the middle of a sequence SHALL abort it without issuing any pending leer, leer_y or desp.
REQ-034 Release of reset SHALL be taken at a clock edge, and the first inicio SHALL be accepted in the first cycle after release.

Configuration
REQ-035 With CONTROL_FILTRO_SOBRECARGA_EN defined, sobrecarga SHALL be set by any inicio that REQ-029 or REQ-030 ignores, and SHALL stay set until reset.
REQ-036 Without CONTROL_FILTRO_SOBRECARGA_EN, sobrecarga SHALL be a constant 0 and no flag register SHALL be built; the port list is identical in both builds.

Structure
REQ-037 The package control_filtro_pkg SHALL hold the state encoding, the constants SEL_B0..SEL_A2 (values 0..5), MAC_PASOS=3 and LATENCIA=12.
REQ-038 The block SHALL be a single module with no sub-modules; the step counter is internal.

Verification
REQ-039 The bench SHALL pulse inicio once after reset and check this cycle sequence: rst_acum; sel=0,1,2; leer; rst_acum; sel=3,4,5; leer_y; desp; listo 12 cycles after inicio.
REQ-040 The bench SHALL pulse inicio again 5 cycles after the first pulse and check that the sequence is unchanged, that only one listo occurs, and that sobrecarga=1 (0 without the macro).
REQ-041 The bench SHALL issue inicio on every 13th cycle for 20 samples and check 20 listo pulses with no overrun.
REQ-042 The bench SHALL assert rst=0 in MAC_B at sel=4 and check that outputs go to their reset values immediately, that leer_y and desp never occur, and that the next inicio yields a full sequence.
REQ-043 The bench SHALL connect the block to the filter with uu as a step from 0 to 1000 and check that y settles monotonically to the DC gain times 1000, within one LSB.
REQ-044 The bench SHALL check every cycle that at most one strobe is high and that sel never exceeds 5 while ocupado=1.
